regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter in front of the register file. Each requester
// has a one-entry holding buffer, and full buffers are granted round-robin.
module regfile_write_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr0_valid,
    input  logic [4:0]  wr0_addr,
    input  logic [31:0] wr0_data,
    output logic        wr0_ready,
    input  logic        wr1_valid,
    input  logic [4:0]  wr1_addr,
    input  logic [31:0] wr1_data,
    output logic        wr1_ready,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    input  logic [4:0]  qaddr1,
    input  logic [4:0]  qaddr2,
    output logic        pend1,
    output logic        pend2
);

    logic        full0_q, full1_q;
    logic [4:0]  addr0_q, addr1_q;
    logic [31:0] data0_q, data1_q;
    logic        last_q;
    logic        regwrite_q;
    logic [4:0]  writereg_q;
    logic [31:0] writedata_q;

    logic        grant0, grant1;
    logic        acc0, acc1;
    logic [4:0]  gaddr;
    logic [31:0] gdata;

    // last_q names the most recent winner; on a tie the other requester goes.
    always_comb begin
        grant0 = full0_q & (~full1_q | last_q);
        grant1 = full1_q & (~full0_q | ~last_q);
        gaddr  = grant1 ? addr1_q : addr0_q;
        gdata  = grant1 ? data1_q : data0_q;
    end

    // Ready is forced high in reset since the buffers are about to be cleared.
    assign wr0_ready = rst | ~full0_q | grant0;
    assign wr1_ready = rst | ~full1_q | grant1;
    assign acc0      = wr0_valid & wr0_ready;
    assign acc1      = wr1_valid & wr1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            full0_q     <= 1'b0;
            full1_q     <= 1'b0;
            addr0_q     <= '0;
            addr1_q     <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
            last_q      <= 1'b1;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            if (acc0) begin
                full0_q <= 1'b1;
                addr0_q <= wr0_addr;
                data0_q <= wr0_data;
            end else if (grant0) begin
                full0_q <= 1'b0;
            end
            if (acc1) begin
                full1_q <= 1'b1;
                addr1_q <= wr1_addr;
                data1_q <= wr1_data;
            end else if (grant1) begin
                full1_q <= 1'b0;
            end
            regwrite_q <= (grant0 | grant1) & (gaddr != 5'd0);
            if (grant0 | grant1) begin
                writereg_q  <= gaddr;
                writedata_q <= gdata;
                last_q      <= grant1;
            end
        end
    end

    assign RegWrite  = regwrite_q;
    assign WriteReg  = writereg_q;
    assign WriteData = writedata_q;

    always_comb begin
        pend1 = (qaddr1 != 5'd0) &
                ((full0_q & (addr0_q == qaddr1)) |
                 (full1_q & (addr1_q == qaddr1)) |
                 (regwrite_q & (writereg_q == qaddr1)));
        pend2 = (qaddr2 != 5'd0) &
                ((full0_q & (addr0_q == qaddr2)) |
                 (full1_q & (addr1_q == qaddr2)) |
                 (regwrite_q & (writereg_q == qaddr2)));
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; each step is checked against
// hand-computed values with immediate assertions.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr0_valid, wr1_valid;
    logic [4:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data;
    logic        wr0_ready, wr1_ready;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  qaddr1, qaddr2;
    logic        pend1, pend2;

    int total = 0;
    int bad   = 0;
    int n0, n1;

    regfile_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .wr0_valid (wr0_valid),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr0_ready (wr0_ready),
        .wr1_valid (wr1_valid),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .wr1_ready (wr1_ready),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .qaddr1    (qaddr1),
        .qaddr2    (qaddr2),
        .pend1     (pend1),
        .pend2     (pend2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
        qaddr1 = '0; qaddr2 = '0;

        // Reset
        tick();
        #1;
        check("rst_ready0", wr0_ready, 1);
        check("rst_ready1", wr1_ready, 1);
        tick();
        rst = 1'b0;
        #1;
        check("rst_regwrite", RegWrite, 0);
        check("rst_writereg", WriteReg, 0);
        check("rst_writedata", WriteData, 0);
        check("rst_pend1", pend1, 0);
        check("rst_pend2", pend2, 0);

        // Simultaneous: requester 0 wins the first tie
        wr0_valid = 1; wr0_addr = 3; wr0_data = 32'h11;
        wr1_valid = 1; wr1_addr = 4; wr1_data = 32'h22;
        tick();
        wr0_valid = 0; wr1_valid = 0;
        #1;
        check("sim_ready1_low", wr1_ready, 0);
        check("sim_ready0", wr0_ready, 1);
        check("sim_rw_c1", RegWrite, 0);
        tick();
        #1;
        check("sim_rw_first", RegWrite, 1);
        check("sim_reg_first", WriteReg, 3);
        check("sim_data_first", WriteData, 32'h11);
        check("sim_ready1_back", wr1_ready, 1);
        tick();
        #1;
        check("sim_rw_second", RegWrite, 1);
        check("sim_reg_second", WriteReg, 4);
        check("sim_data_second", WriteData, 32'h22);
        tick();
        #1;
        check("sim_rw_idle", RegWrite, 0);

        // Single write with hazard query
        qaddr1 = 5;
        wr0_valid = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
        #1;
        check("single_ready", wr0_ready, 1);
        check("single_pend_pre", pend1, 0);
        tick();
        wr0_valid = 0;
        #1;
        check("single_pend_buf", pend1, 1);
        check("single_rw_c1", RegWrite, 0);
        tick();
        #1;
        check("single_rw", RegWrite, 1);
        check("single_reg", WriteReg, 5);
        check("single_data", WriteData, 32'hDEADBEEF);
        check("single_pend_wb", pend1, 1);
        tick();
        #1;
        check("single_rw_done", RegWrite, 0);
        check("single_pend_done", pend1, 0);
        qaddr1 = 0;

        // Sustained contention, restarting from reset so requester 0 goes first
        rst = 1;
        tick();
        rst = 0;
        n0 = 0; n1 = 0;
        wr0_valid = 1; wr0_addr = 10; wr0_data = 32'hA0;
        wr1_valid = 1; wr1_addr = 20; wr1_data = 32'hB1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) begin
                wr0_valid = 0; wr1_valid = 0;
            end
            #1;
            check($sformatf("cont_rw_%0d", i), RegWrite, 1);
            check($sformatf("cont_reg_%0d", i), WriteReg, (i % 2 == 1) ? 20 : 10);
            if (RegWrite && WriteReg == 10) n0++;
            if (RegWrite && WriteReg == 20) n1++;
        end
        check("cont_count0", n0, 4);
        check("cont_count1", n1, 4);
        tick();
        tick();
        #1;
        check("cont_drained", RegWrite, 0);
        check("cont_ready0", wr0_ready, 1);
        check("cont_ready1", wr1_ready, 1);

        // Register zero
        qaddr1 = 0; qaddr2 = 0;
        wr1_valid = 1; wr1_addr = 0; wr1_data = 32'hFFFFFFFF;
        tick();
        wr1_valid = 0;
        #1;
        check("zero_ready_grant", wr1_ready, 1);
        check("zero_pend1", pend1, 0);
        check("zero_pend2", pend2, 0);
        tick();
        #1;
        check("zero_rw", RegWrite, 0);
        check("zero_data", WriteData, 32'hFFFFFFFF);
        check("zero_ready", wr1_ready, 1);
        check("zero_pend2_wb", pend2, 0);
        tick();
        #1;
        check("zero_rw_after", RegWrite, 0);

        // Reset mid-operation
        qaddr1 = 7; qaddr2 = 8;
        wr0_valid = 1; wr0_addr = 7; wr0_data = 32'h77;
        wr1_valid = 1; wr1_addr = 8; wr1_data = 32'h88;
        tick();
        wr1_valid = 0;
        rst = 1;
        #1;
        check("mid_pend1_pre", pend1, 1);
        check("mid_ready0_rst", wr0_ready, 1);
        check("mid_ready1_rst", wr1_ready, 1);
        tick();
        rst = 0; wr0_valid = 0;
        #1;
        check("mid_rw", RegWrite, 0);
        check("mid_pend1", pend1, 0);
        check("mid_pend2", pend2, 0);
        tick();
        #1;
        check("mid_rw_next", RegWrite, 0);
        wr0_valid = 1; wr0_addr = 9;  wr0_data = 32'h99;
        wr1_valid = 1; wr1_addr = 10; wr1_data = 32'hAA;
        tick();
        wr0_valid = 0; wr1_valid = 0;
        tick();
        #1;
        check("mid_tie_reg", WriteReg, 9);
        check("mid_tie_data", WriteData, 32'h99);
        tick();
        #1;
        check("mid_tie_reg2", WriteReg, 10);
        tick();

        // Back-to-back from requester 0
        qaddr1 = 0; qaddr2 = 0;
        for (int n = 1; n <= 4; n++) begin
            wr0_valid = 1; wr0_addr = 5'(n); wr0_data = 32'h100 + n;
            #1;
            check($sformatf("b2b_ready_%0d", n), wr0_ready, 1);
            tick();
            if (n >= 2) begin
                check($sformatf("b2b_rw_%0d", n - 1), RegWrite, 1);
                check($sformatf("b2b_reg_%0d", n - 1), WriteReg, n - 1);
                check($sformatf("b2b_data_%0d", n - 1), WriteData, 32'h100 + n - 1);
            end
        end
        wr0_valid = 0;
        tick();
        #1;
        check("b2b_rw_4", RegWrite, 1);
        check("b2b_reg_4", WriteReg, 4);
        check("b2b_data_4", WriteData, 32'h104);
        tick();
        #1;
        check("b2b_idle", RegWrite, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
